// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB bus types and arbiter definitions.
package def;

    localparam int unsigned mas_num    = 2;
    localparam int unsigned def_master = 0;

    typedef enum logic [1:0] {
        H_IDLE   = 2'b00,
        H_BUSY   = 2'b01,
        H_NONSEQ = 2'b10,
        H_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        B_SINGLE = 3'b000,
        B_INCR   = 3'b001,
        B_WRAP4  = 3'b010,
        B_INCR4  = 3'b011,
        B_WRAP8  = 3'b100,
        B_INCR8  = 3'b101,
        B_WRAP16 = 3'b110,
        B_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        R_OKAY  = 2'b00,
        R_ERROR = 2'b01,
        R_RETRY = 2'b10,
        R_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BURST  = 2'b01,
        UNDEF  = 2'b10,
        LOCKED = 2'b11
    } arb_state_t;

    // Beats in a burst; INCR is open-ended and reports a single beat.
    function automatic logic [4:0] calc_beat(input hburst_t burst);
        logic [4:0] beats;
        case (burst)
            B_WRAP4,  B_INCR4:  beats = 5'd4;
            B_WRAP8,  B_INCR8:  beats = 5'd8;
            B_WRAP16, B_INCR16: beats = 5'd16;
            default:            beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible master after the pointer.
module ahb_rr_pick #(
    parameter int unsigned n = 2,
    parameter int unsigned w = 1
) (
    input  logic [n-1:0] eligible,
    input  logic [w-1:0] pointer,
    output logic [n-1:0] winner,
    output logic         valid
);

    logic [w-1:0] start;
    logic [n-1:0] rot;
    logic [n-1:0] win_rot;

    always_comb begin
        start = (32'(pointer) >= n - 1) ? '0 : pointer + 1'b1;
        // Rotate so the search origin sits at bit 0, pick lowest set bit, rotate back.
        rot     = n'({eligible, eligible} >> start);
        win_rot = '0;
        valid   = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (!valid && rot[i]) begin
                win_rot[i] = 1'b1;
                valid      = 1'b1;
            end
        end
        winner = n'(({win_rot, win_rot} << start) >> n);
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: burst-aware, round-robin, lock and split support.
module ahb_arbiter
    import def::*;
#(
    parameter int unsigned mas_num        = def::mas_num,
    parameter int unsigned default_master = def::def_master,
    parameter int unsigned mw             = (mas_num > 1) ? $clog2(mas_num) : 1
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [mas_num-1:0] hbusreq,
    input  logic [mas_num-1:0] hlock,
    input  htrans_t            htrans,
    input  hburst_t            hburst,
    input  logic               hready,
    input  hresp_t             hresp,
    input  logic [mas_num-1:0] hsplit,
    output logic [mas_num-1:0] hgrant,
    output logic [mw-1:0]      hmaster,
    output logic               hmastlock
);

    localparam logic [mas_num-1:0] def_oh  = mas_num'(1) << default_master;
    localparam logic [mw-1:0]      def_idx = mw'(default_master);

    function automatic logic [mw-1:0] oh2idx(input logic [mas_num-1:0] oh);
        logic [mw-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < mas_num; i++) begin
            if (oh[i]) idx = mw'(i);
        end
        return idx;
    endfunction

    arb_state_t         state, state_nxt;
    logic [4:0]         cnt, cnt_nxt;
    logic [mas_num-1:0] split_mask, split_set, mask_nxt;
    logic [mw-1:0]      rr_ptr;
    logic [mas_num-1:0] grant_nxt;
    logic [mas_num-1:0] eligible;
    logic [mas_num-1:0] pick_oh;
    logic               pick_valid;
    logic [mw-1:0]      grant_idx;
    logic               owner_req;
    logic               lock_req;
    logic               rearb;

    assign grant_idx = oh2idx(hgrant);
    assign owner_req = hbusreq[grant_idx];
    assign lock_req  = hlock[grant_idx] & hbusreq[grant_idx];

    // A split seen this cycle already excludes its master from this decision.
    assign split_set = (hready && hresp == R_SPLIT) ? (mas_num'(1) << hmaster) : '0;
    assign mask_nxt  = (split_mask & ~hsplit) | split_set;
    assign eligible  = hbusreq & ~(split_mask | split_set);

    ahb_rr_pick #(
        .n (mas_num),
        .w (mw)
    ) u_pick (
        .eligible (eligible),
        .pointer  (rr_ptr),
        .winner   (pick_oh),
        .valid    (pick_valid)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rearb     = 1'b0;
        if (hready) begin
            if (hresp != R_OKAY) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
                rearb     = 1'b1;
            end else begin
                if (htrans == H_NONSEQ && hburst != B_INCR)
                    cnt_nxt = calc_beat(hburst) - 5'd1;
                else if (htrans == H_SEQ && cnt != '0)
                    cnt_nxt = cnt - 5'd1;

                case (state)
                    IDLE: begin
                        if (htrans == H_NONSEQ && hburst != B_INCR && calc_beat(hburst) > 5'd1)
                            state_nxt = BURST;
                        else if (htrans == H_NONSEQ && hburst == B_INCR)
                            state_nxt = UNDEF;
                        else
                            rearb = 1'b1;
                    end
                    BURST: begin
                        if (htrans == H_SEQ && cnt == 5'd1) begin
                            state_nxt = IDLE;
                            rearb     = 1'b1;
                        end
                    end
                    UNDEF: begin
                        if (!owner_req || htrans == H_NONSEQ || htrans == H_IDLE) begin
                            state_nxt = IDLE;
                            rearb     = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!hlock[grant_idx]) begin
                            state_nxt = IDLE;
                            rearb     = 1'b1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            // A locking owner keeps the bus regardless of burst progress.
            if (lock_req) begin
                state_nxt = LOCKED;
                rearb     = 1'b0;
            end
        end

        grant_nxt = hgrant;
        if (rearb)
            grant_nxt = pick_valid ? pick_oh : def_oh;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= IDLE;
            cnt        <= '0;
            split_mask <= '0;
            rr_ptr     <= def_idx;
            hgrant     <= def_oh;
            hmaster    <= def_idx;
            hmastlock  <= 1'b0;
        end else begin
            split_mask <= mask_nxt;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hgrant     <= grant_nxt;
            if (grant_nxt != hgrant)
                rr_ptr <= oh2idx(grant_nxt);
            if (hready) begin
                hmaster   <= grant_idx;
                hmastlock <= lock_req;
            end
        end
    end

endmodule
